fpu_dispatch: RTL
=================

# fpu_dispatch

Parametrised issue/complete engine between the multi-cycle core and N AXI4-Stream floating-point units (add/sub, mul, div, compare, cvt, sqrt, …). It accepts one operation at a time from the core's EXECUTE stage and drives the selected unit's A/B/OP source channels and R sink channel with protocol-correct handshakes. It returns a single result pulse and provides a clean stall signal, with timeout and bad-unit error reporting.

## Interface
Parameters:
- N_UNITS, 7, number of attached FP units (1..16)
- DATA_W, 32, operand/result width
- OP_W, 8, OP channel width
- HAS_B, 7'b0001111, per-unit bit: unit has a B operand channel
- HAS_OP, 7'b0001001, per-unit bit: unit has an OP channel
- TMO_W, 12, timeout counter width; timeout = 2^TMO_W-1 cycles

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- ISSUE_VALID  in  1  core requests an operation
- ISSUE_READY  out  1  engine idle, request accepted on VALID&READY
- ISSUE_UNIT  in  4  target unit index
- ISSUE_A / ISSUE_B  in  DATA_W  operands
- ISSUE_OP  in  OP_W  operation code
- RES_VALID  out  1  one-cycle completion pulse
- RES_DATA  out  DATA_W  result (0 on error/timeout)
- RES_ERR  out  1  qualifies RES_VALID: bad unit index
- RES_TMO  out  1  qualifies RES_VALID: timeout
- STALL  out  1  core must hold its state machine
- U_A_TDATA / U_B_TDATA  out  N_UNITS*DATA_W  per-unit operand data, unit u at [u*DATA_W +: DATA_W]
- U_OP_TDATA  out  N_UNITS*OP_W  per-unit op data
- U_A_TVALID / U_B_TVALID / U_OP_TVALID  out  N_UNITS  source valids
- U_A_TREADY / U_B_TREADY / U_OP_TREADY  in  N_UNITS  source readies
- U_R_TDATA  in  N_UNITS*DATA_W  result data
- U_R_TVALID  in  N_UNITS  result valid
- U_R_TREADY  out  N_UNITS  result ready

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: ISSUE_READY=1. On ISSUE_VALID:
  - ISSUE_UNIT >= N_UNITS -> DONE with RES_ERR=1.
  - Otherwise latch unit, A, B, OP -> SEND. Set pending flags: a=1, b=HAS_B[u], op=HAS_OP[u]. Clear timer.
- SEND: each pending channel of unit u holds TVALID=1 with stable TDATA until TVALID&TREADY; its flag clears and TVALID drops next cycle. Channels complete independently, in any order. U_R_TREADY[u]=1. All flags clear -> WAIT.
- WAIT: U_R_TREADY[u]=1 until U_R_TVALID[u].
- Result capture: valid in SEND or WAIT. On R_TVALID&R_TREADY, RES_DATA<=U_R_TDATA[u] -> DONE. R_TREADY drops next cycle.
- DONE: RES_VALID=1 for exactly one cycle -> IDLE.
- Timer: increments every cycle in SEND/WAIT. Reaching all-ones -> drop all valids/readies, DONE with RES_TMO=1, RES_DATA=0. This is a fault path; the AXIS violation is accepted.
- Non-selected units: all TVALID/TREADY 0. TDATA is 0 for any channel not valid.
- STALL = ISSUE_VALID & ISSUE_READY | state∈{SEND,WAIT}. Deasserts in the DONE cycle.

## Timing
- Reset: state IDLE, ISSUE_READY=1 after reset exits, every other output 0.
- Reset mid-operation abandons the op: all valids/readies low the cycle after RST_N sampled low, no RES_VALID.
- Accept at cycle 0 -> source TVALIDs high cycle 1. Best-case result: R_TVALID in cycle 1 -> RES_VALID cycle 2. Issue-to-result minimum 2 cycles.
- Bad index: accept cycle 0 -> RES_VALID+RES_ERR cycle 1.
- Next issue accepted earliest in the cycle after DONE.
- All outputs registered except ISSUE_READY and STALL, which decode state combinationally.

## Structure
- Package fpu_dispatch_pkg:
  - state enum
  - unit indices: ADDSUB=0, MUL=1, DIV=2, COMP=3, FCVTSW=4, FCVTWS=5, FSQRTS=6
  - op codes: OP_ADD=8'h00, OP_SUB=8'h01, OP_FEQ=8'h14, OP_FLT=8'h0C, OP_FLE=8'h1C
  - default HAS_B/HAS_OP masks
- Sub-module axis_hold: one-beat AXIS source register with pending flag, instantiated per channel type (A, B, OP). The fan-out to the selected unit is done in the top.

## Test plan
- ADDSUB, A=0x3F800000, B=0x40000000, OP=0x00. Unit readies all 1, R returns 0x40400000 two cycles later -> RES_VALID once with RES_DATA=0x40400000. STALL high from issue until the DONE cycle.
- MUL with A_TREADY delayed 3 cycles and B_TREADY delayed 1 -> B_TVALID drops after 1 cycle, A_TVALID held 3 cycles with stable data. U_R_TREADY[1] asserted throughout.
- FSQRTS (unit 6, no B/OP) -> U_B_TVALID[6] and U_OP_TVALID[6] never assert. Result 0x40000000 for A=0x40800000.
- ISSUE_UNIT=9 -> RES_VALID & RES_ERR next cycle, RES_DATA=0, no unit valids.
- DIV with R_TVALID never asserted, TMO_W=4 -> RES_TMO pulse 15 cycles after SEND entry. All unit signals low afterwards. Next issue is accepted.
- RST_N low during WAIT -> no RES_VALID, all U_* valids/readies 0 next cycle, ISSUE_READY=1 after release.

Source files
------------

// File: rtl/fpu_dispatch_pkg.sv
// fpu_dispatch_pkg
// Shared definitions for the FP-unit dispatch engine.
//   state_t          : engine FSM states
//   unit indices     : slot numbers of the attached FP units
//   op codes         : OP-channel encodings understood by the units
//   HAS_*_DEFAULT    : default per-unit channel-presence masks for the 7-unit slice
package fpu_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int unsigned ADDSUB = 0;
    localparam int unsigned MUL    = 1;
    localparam int unsigned DIV    = 2;
    localparam int unsigned COMP   = 3;
    localparam int unsigned FCVTSW = 4;
    localparam int unsigned FCVTWS = 5;
    localparam int unsigned FSQRTS = 6;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_FEQ = 8'h14;
    localparam logic [7:0] OP_FLT = 8'h0C;
    localparam logic [7:0] OP_FLE = 8'h1C;

    localparam logic [6:0] HAS_B_DEFAULT  = 7'b0001111;
    localparam logic [6:0] HAS_OP_DEFAULT = 7'b0001001;

endpackage

// File: rtl/fpu_dispatch_axis.sv
// axis_hold
// One-beat AXI4-Stream source register. A load captures a beat and raises
// the pending flag (tvalid); the beat is held stable until tvalid & tready,
// after which tvalid drops and tdata returns to zero. flush abandons the beat.
//   CLK, RST_N  : clock, synchronous active-low reset
//   load        : capture load_data; pending set to load_pend
//   load_pend   : channel is used by this operation
//   load_data   : beat to send
//   flush       : drop any pending beat
//   tready      : sink ready
//   tvalid      : pending flag / source valid
//   tdata       : held beat, zero whenever tvalid is low
module axis_hold #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic         load_pend,
    input  logic [W-1:0] load_data,
    input  logic         flush,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata
);

    always_ff @(posedge CLK) begin
        if (!RST_N || flush) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= load_pend;
            tdata  <= load_pend ? load_data : '0;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
            tdata  <= '0;
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// fpu_dispatch
// Issue/complete engine between the core EXECUTE stage and N_UNITS AXI4-Stream
// FP units. One operation in flight: operands/op are sent on the selected
// unit's A/B/OP channels, the result is taken from its R channel and returned
// as a single RES_VALID pulse. Bad unit index and timeout complete with an
// error flag and zero data.
//   CLK, RST_N                      : clock, synchronous active-low reset
//   ISSUE_VALID/READY/UNIT/A/B/OP   : issue handshake from the core
//   RES_VALID/DATA/ERR/TMO          : one-cycle completion pulse and qualifiers
//   STALL                           : core hold request
//   U_A/U_B/U_OP_TDATA/TVALID/TREADY: per-unit source channels
//   U_R_TDATA/TVALID/TREADY         : per-unit result channels
module fpu_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int unsigned         N_UNITS = 7,
    parameter int unsigned         DATA_W  = 32,
    parameter int unsigned         OP_W    = 8,
    parameter logic [N_UNITS-1:0]  HAS_B   = N_UNITS'(HAS_B_DEFAULT),
    parameter logic [N_UNITS-1:0]  HAS_OP  = N_UNITS'(HAS_OP_DEFAULT),
    parameter int unsigned         TMO_W   = 12
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ISSUE_VALID,
    output logic                       ISSUE_READY,
    input  logic [3:0]                 ISSUE_UNIT,
    input  logic [DATA_W-1:0]          ISSUE_A,
    input  logic [DATA_W-1:0]          ISSUE_B,
    input  logic [OP_W-1:0]            ISSUE_OP,
    output logic                       RES_VALID,
    output logic [DATA_W-1:0]          RES_DATA,
    output logic                       RES_ERR,
    output logic                       RES_TMO,
    output logic                       STALL,
    output logic [N_UNITS*DATA_W-1:0]  U_A_TDATA,
    output logic [N_UNITS*DATA_W-1:0]  U_B_TDATA,
    output logic [N_UNITS*OP_W-1:0]    U_OP_TDATA,
    output logic [N_UNITS-1:0]         U_A_TVALID,
    output logic [N_UNITS-1:0]         U_B_TVALID,
    output logic [N_UNITS-1:0]         U_OP_TVALID,
    input  logic [N_UNITS-1:0]         U_A_TREADY,
    input  logic [N_UNITS-1:0]         U_B_TREADY,
    input  logic [N_UNITS-1:0]         U_OP_TREADY,
    input  logic [N_UNITS*DATA_W-1:0]  U_R_TDATA,
    input  logic [N_UNITS-1:0]         U_R_TVALID,
    output logic [N_UNITS-1:0]         U_R_TREADY
);

    // Timeout fires on the cycle the timer would step onto all-ones, so
    // SEND/WAIT lasts at most 2^TMO_W-1 cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    state_t               state_q, state_d;
    logic [N_UNITS-1:0]   sel_q, issue_sel;
    logic                 unit_ok, accept, load, busy;
    logic                 r_ready_q, r_capture, tmo_hit, finish;
    logic [TMO_W-1:0]     timer_q;
    logic                 a_valid, b_valid, op_valid;
    logic [DATA_W-1:0]    a_data, b_data, r_data_sel, res_data_q;
    logic [OP_W-1:0]      op_data;
    logic                 res_valid_q, res_err_q, res_tmo_q;

    always_comb begin
        issue_sel = '0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            issue_sel[u] = (ISSUE_UNIT == 4'(u));
        end
    end

    always_comb begin
        r_data_sel = '0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            if (sel_q[u]) r_data_sel = U_R_TDATA[u*DATA_W +: DATA_W];
        end
    end

    assign unit_ok   = ({1'b0, ISSUE_UNIT} < 5'(N_UNITS));
    assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT);
    assign accept    = ISSUE_VALID && (state_q == ST_IDLE);
    assign load      = accept && unit_ok;
    assign r_capture = busy && r_ready_q && |(U_R_TVALID & sel_q);
    assign tmo_hit   = busy && !r_capture && (timer_q == TMO_LAST);
    assign finish    = r_capture || tmo_hit;

    axis_hold #(.W(DATA_W)) u_hold_a (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load),
        .load_pend (1'b1),
        .load_data (ISSUE_A),
        .flush     (finish),
        .tready    (|(U_A_TREADY & sel_q)),
        .tvalid    (a_valid),
        .tdata     (a_data)
    );

    axis_hold #(.W(DATA_W)) u_hold_b (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load),
        .load_pend (|(HAS_B & issue_sel)),
        .load_data (ISSUE_B),
        .flush     (finish),
        .tready    (|(U_B_TREADY & sel_q)),
        .tvalid    (b_valid),
        .tdata     (b_data)
    );

    axis_hold #(.W(OP_W)) u_hold_op (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load),
        .load_pend (|(HAS_OP & issue_sel)),
        .load_data (ISSUE_OP),
        .flush     (finish),
        .tready    (|(U_OP_TREADY & sel_q)),
        .tvalid    (op_valid),
        .tdata     (op_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (ISSUE_VALID) state_d = unit_ok ? ST_SEND : ST_DONE;
            ST_SEND: begin
                if (finish)                                state_d = ST_DONE;
                else if (!(a_valid || b_valid || op_valid)) state_d = ST_WAIT;
            end
            ST_WAIT: if (finish) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sel_q       <= '0;
            r_ready_q   <= 1'b0;
            timer_q     <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_tmo_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_tmo_q   <= 1'b0;
            res_data_q  <= '0;
            if (load) begin
                sel_q     <= issue_sel;
                r_ready_q <= 1'b1;
                timer_q   <= '0;
            end else begin
                if (busy)   timer_q   <= timer_q + 1'b1;
                if (finish) r_ready_q <= 1'b0;
            end
            if (accept && !unit_ok) begin
                res_valid_q <= 1'b1;
                res_err_q   <= 1'b1;
            end
            if (r_capture) begin
                res_valid_q <= 1'b1;
                res_data_q  <= r_data_sel;
            end
            if (tmo_hit) begin
                res_valid_q <= 1'b1;
                res_tmo_q   <= 1'b1;
            end
        end
    end

    assign ISSUE_READY = (state_q == ST_IDLE);
    assign STALL       = (ISSUE_VALID && ISSUE_READY) || busy;
    assign RES_VALID   = res_valid_q;
    assign RES_DATA    = res_data_q;
    assign RES_ERR     = res_err_q;
    assign RES_TMO     = res_tmo_q;

    // sel_q is one-hot and the held data is zero when not valid, so gating
    // by sel_q alone keeps every non-selected lane at zero.
    assign U_A_TVALID  = sel_q & {N_UNITS{a_valid}};
    assign U_B_TVALID  = sel_q & {N_UNITS{b_valid}};
    assign U_OP_TVALID = sel_q & {N_UNITS{op_valid}};
    assign U_R_TREADY  = sel_q & {N_UNITS{r_ready_q}};

    always_comb begin
        U_A_TDATA  = '0;
        U_B_TDATA  = '0;
        U_OP_TDATA = '0;
        for (int unsigned u = 0; u < N_UNITS; u++) begin
            if (sel_q[u]) begin
                U_A_TDATA[u*DATA_W +: DATA_W] = a_data;
                U_B_TDATA[u*DATA_W +: DATA_W] = b_data;
                U_OP_TDATA[u*OP_W +: OP_W]    = op_data;
            end
        end
    end

endmodule
